capture_controller: RTL and testbench
=====================================

# capture_controller

Sequencing controller for the logic-analyzer capture path. It programs the sample-rate divider's `rate_sel` and consumes its one-cycle `sample_en` pulses. On each pulse it writes the channel word into a circular sample RAM. It runs a pre-trigger / armed / post-trigger state machine so the RAM ends up holding exactly `DEPTH` samples around a masked-pattern trigger.

## Interface
Parameters:
- `CH_W`, default 8, channel (sample word) width.
- `ADDR_W`, default 10, sample RAM address width; `DEPTH = 2**ADDR_W`.

Ports:
- `clk`  in  1  capture clock, same clock as the divider. The reset `rst_n` is asynchronous, active-low; the clock is `clk`.
- `rst_n`  in  1  asynchronous active-low reset.
- `arm`  in  1  one-cycle start request.
- `abort`  in  1  one-cycle cancel request.
- `cfg_rate_sel`  in  3  rate setting; latched on accepted arm.
- `cfg_pretrig`  in  ADDR_W  number of pre-trigger samples; latched on accepted arm.
- `cfg_trig_mask`  in  CH_W  trigger care bits; latched on accepted arm.
- `cfg_trig_val`  in  CH_W  trigger pattern; latched on accepted arm.
- `din`  in  CH_W  channel inputs, already synchronised to `clk`.
- `sample_en`  in  1  pulse from the divider.
- `rate_sel`  out  3  drives the divider.
- `wr_en`  out  1  RAM write strobe.
- `wr_addr`  out  ADDR_W  RAM write address.
- `wr_data`  out  CH_W  RAM write data.
- `busy`  out  1  high in PRE, ARMED and POST.
- `done`  out  1  level; high in DONE.
- `trig_addr`  out  ADDR_W  RAM address of the trigger sample.
- `start_addr`  out  ADDR_W  address of the oldest valid sample, `trig_addr - pretrig` mod `DEPTH`.

## Operation
- States: IDLE, PRE, ARMED, POST, DONE.
- Reset: state IDLE. All outputs and internal counters/pointers reset to 0: `rate_sel`, `wr_en`, `wr_addr`, `wr_data`, `busy`, `done`, `trig_addr`, `start_addr`, the write pointer, and the sample counter.
- Accepted arm (state IDLE or DONE, `abort` low):
  - Latch all `cfg_*` inputs; `rate_sel` <= `cfg_rate_sel`.
  - Write pointer <= 0, sample counter <= 0.
  - Next state is PRE, or ARMED if `cfg_pretrig == 0`.
- `arm` is ignored in PRE, ARMED and POST.
- Each `sample_en` in PRE, ARMED or POST writes `din` to the write pointer, then the pointer increments. The pointer wraps from `DEPTH-1` to 0.
- PRE: the counter increments per sample. When the count reaches the latched pretrig, go to ARMED.
- ARMED: every sample is written; older samples are overwritten as the pointer wraps. A sample triggers when `(din & mask) == (val & mask)`; `mask == 0` triggers on the first ARMED sample. On the triggering sample:
  - `trig_addr` <= pointer.
  - `start_addr` <= pointer − pretrig (mod `DEPTH`).
  - Counter <= 0.
  - If `DEPTH-1-pretrig == 0`, go to DONE; otherwise go to POST.
- POST: each sample increments the counter. The sample for which the counter reaches `DEPTH-1-pretrig` is written and the state moves to DONE.
- Total samples written from pretrig through post is exactly `DEPTH`, so the RAM holds a contiguous window starting at `start_addr`.
- DONE: `done` high. `trig_addr`/`start_addr` hold until the next accepted arm.
- Abort:
  - In any state, `abort` returns to IDLE, clears `busy`/`done`, and suppresses any write that cycle.
  - `abort` has priority over `sample_en` and over `arm`.
  - `rate_sel` keeps its value.
- Arithmetic: all address math is ADDR_W-bit modulo. The counter is ADDR_W bits wide. `cfg_pretrig` max is `DEPTH-1`, which gives zero post samples.

## Timing
- Latency: `sample_en` high in cycle N → `wr_en` high in N+1, with `wr_addr` = pointer at N and `wr_data` = `din` at N.
- `wr_en` is a single-cycle pulse per accepted sample.
- State transitions caused by the sample at N take effect at N+1. `done` rises in the same cycle as the final `wr_en`, and `busy` falls in that cycle.
- The trigger compare uses `din` in the `sample_en` cycle; there is no extra pipelining.
- `rate_sel` updates in the cycle after an accepted arm. The divider resynchronises on the change, so the first `sample_en` can come at any later cycle; the controller makes no assumption about pulse spacing.
- `sample_en` while IDLE or DONE: no write, no state change.

## Structure
- Shared package `la_pkg`: the `cap_state_t` enum (IDLE, PRE, ARMED, POST, DONE), the `RATE_SEL_W = 3` constant, and default `CH_W`/`ADDR_W`.
- Optional sub-module `trigger_matcher`: a combinational masked compare, `din`/mask/val → `hit`. Everything else is inline.

## Test plan
All scenarios use `ADDR_W=4` (`DEPTH=16`) and `CH_W=8`; `sample_en` is tied high unless stated.
1. Arm with pretrig=4, mask=0xFF, val=0x0A, `din` counting 0,1,2,… → trig_addr=0x0A, start_addr=0x06, exactly 16 `wr_en` from trigger−4 to trigger+11, `done` high with `wr_en` at addr 0x05, `busy` low.
2. pretrig=0, mask=0x00 → trigger on the first sample, trig_addr=0, start_addr=0, 16 writes, then DONE.
3. pretrig=15, mask=0x01, val=0x01, `din`=0 for 30 samples then 0x01 → write pointer wraps (addr 0xF→0x0 observed), zero post samples, done in the cycle of the trigger write, start_addr=trig_addr+1 (mod 16).
4. `sample_en` every 3rd cycle with cfg_rate_sel=5 → `rate_sel`=5 one cycle after arm; each `wr_en` exactly one cycle after its `sample_en`; no writes between pulses.
5. Abort in POST coinciding with `sample_en` → no write that cycle, IDLE next, `busy`=`done`=0. Arm while busy → ignored, cfg unchanged. Arm+abort together in IDLE → stays IDLE.
6. Assert `rst_n` low mid-POST → all outputs 0 asynchronously. Re-arm after release → capture as in scenario 1.

Source files
------------

// File: rtl/la_pkg.sv
// Shared types and constants for the logic-analyzer capture path.
package la_pkg;

   localparam int unsigned RATE_SEL_W = 3;
   localparam int unsigned DEF_CH_W   = 8;
   localparam int unsigned DEF_ADDR_W = 10;

   typedef enum logic [2:0] {
      StIdle,
      StPre,
      StArmed,
      StPost,
      StDone
   } cap_state_t;

endpackage

// File: rtl/trigger_matcher.sv
// Masked pattern compare: hit when every care bit of din equals the pattern.
module trigger_matcher #(
   parameter int unsigned CH_W = 8
) (
   input  logic [CH_W-1:0] din,
   input  logic [CH_W-1:0] mask,
   input  logic [CH_W-1:0] val,
   output logic            hit
);

   // An all-zero mask matches unconditionally.
   assign hit = ((din ^ val) & mask) == '0;

endmodule

// File: rtl/capture_controller.sv
// Capture sequencer: pre-trigger fill, armed search, post-trigger fill into a
// circular sample RAM so that exactly DEPTH samples surround the trigger.
module capture_controller
   import la_pkg::*;
#(
   parameter int unsigned CH_W   = DEF_CH_W,
   parameter int unsigned ADDR_W = DEF_ADDR_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  arm,
   input  logic                  abort,
   input  logic [RATE_SEL_W-1:0] cfg_rate_sel,
   input  logic [ADDR_W-1:0]     cfg_pretrig,
   input  logic [CH_W-1:0]       cfg_trig_mask,
   input  logic [CH_W-1:0]       cfg_trig_val,
   input  logic [CH_W-1:0]       din,
   input  logic                  sample_en,
   output logic [RATE_SEL_W-1:0] rate_sel,
   output logic                  wr_en,
   output logic [ADDR_W-1:0]     wr_addr,
   output logic [CH_W-1:0]       wr_data,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_W-1:0]     trig_addr,
   output logic [ADDR_W-1:0]     start_addr
);

   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

   cap_state_t              state_q, state_d;
   logic [ADDR_W-1:0]       ptr_q, ptr_d;
   logic [ADDR_W-1:0]       cnt_q, cnt_d;
   logic [ADDR_W-1:0]       pretrig_q, pretrig_d;
   logic [CH_W-1:0]         mask_q, mask_d;
   logic [CH_W-1:0]         val_q, val_d;
   logic [RATE_SEL_W-1:0]   rate_sel_q, rate_sel_d;
   logic                    wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]       wr_addr_q, wr_addr_d;
   logic [CH_W-1:0]         wr_data_q, wr_data_d;
   logic [ADDR_W-1:0]       trig_addr_q, trig_addr_d;
   logic [ADDR_W-1:0]       start_addr_q, start_addr_d;

   logic                    hit;
   logic                    capturing;
   logic                    take_sample;
   logic [ADDR_W-1:0]       cnt_inc;
   logic [ADDR_W-1:0]       post_len;

   trigger_matcher #(
      .CH_W (CH_W)
   ) u_trigger_matcher (
      .din  (din),
      .mask (mask_q),
      .val  (val_q),
      .hit  (hit)
   );

   // Next-state, sample write and trigger bookkeeping.
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      cnt_d        = cnt_q;
      pretrig_d    = pretrig_q;
      mask_d       = mask_q;
      val_d        = val_q;
      rate_sel_d   = rate_sel_q;
      wr_en_d      = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      trig_addr_d  = trig_addr_q;
      start_addr_d = start_addr_q;

      capturing   = (state_q == StPre) || (state_q == StArmed) || (state_q == StPost);
      take_sample = capturing && sample_en && !abort;
      cnt_inc     = cnt_q + 1'b1;
      // Samples still owed after the trigger so the window totals DEPTH.
      post_len    = ADDR_MAX - pretrig_q;

      if (take_sample) begin
         wr_en_d   = 1'b1;
         wr_addr_d = ptr_q;
         wr_data_d = din;
         ptr_d     = ptr_q + 1'b1;
      end

      if (abort) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle, StDone: begin
               if (arm) begin
                  pretrig_d    = cfg_pretrig;
                  mask_d       = cfg_trig_mask;
                  val_d        = cfg_trig_val;
                  rate_sel_d   = cfg_rate_sel;
                  ptr_d        = '0;
                  cnt_d        = '0;
                  trig_addr_d  = '0;
                  start_addr_d = '0;
                  state_d      = (cfg_pretrig == '0) ? StArmed : StPre;
               end
            end
            StPre: begin
               if (sample_en) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == pretrig_q) state_d = StArmed;
               end
            end
            StArmed: begin
               if (sample_en && hit) begin
                  trig_addr_d  = ptr_q;
                  start_addr_d = ptr_q - pretrig_q;
                  cnt_d        = '0;
                  state_d      = (post_len == '0) ? StDone : StPost;
               end
            end
            StPost: begin
               if (sample_en) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == post_len) state_d = StDone;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // State and output registers, all cleared by asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         ptr_q        <= '0;
         cnt_q        <= '0;
         pretrig_q    <= '0;
         mask_q       <= '0;
         val_q        <= '0;
         rate_sel_q   <= '0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         trig_addr_q  <= '0;
         start_addr_q <= '0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         cnt_q        <= cnt_d;
         pretrig_q    <= pretrig_d;
         mask_q       <= mask_d;
         val_q        <= val_d;
         rate_sel_q   <= rate_sel_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         trig_addr_q  <= trig_addr_d;
         start_addr_q <= start_addr_d;
      end
   end

   assign rate_sel   = rate_sel_q;
   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign trig_addr  = trig_addr_q;
   assign start_addr = start_addr_q;
   // Status follows the registered state, so done rises with the final wr_en.
   assign busy       = (state_q == StPre) || (state_q == StArmed) || (state_q == StPost);
   assign done       = (state_q == StDone);

endmodule

// File: tb/tb_capture_controller.sv
// Bench for capture_controller: directed scenarios plus random traffic, all
// checked cycle by cycle against a sample-index model of the capture window.
module tb_capture_controller;

   localparam int CH_W   = 8;
   localparam int ADDR_W = 4;
   localparam int DEPTH  = 16;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              arm = 1'b0;
   logic              abort = 1'b0;
   logic [2:0]        cfg_rate_sel = '0;
   logic [ADDR_W-1:0] cfg_pretrig = '0;
   logic [CH_W-1:0]   cfg_trig_mask = '0;
   logic [CH_W-1:0]   cfg_trig_val = '0;
   logic [CH_W-1:0]   din = '0;
   logic              sample_en = 1'b0;
   logic [2:0]        rate_sel;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [CH_W-1:0]   wr_data;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] trig_addr;
   logic [ADDR_W-1:0] start_addr;

   capture_controller #(
      .CH_W   (CH_W),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .arm           (arm),
      .abort         (abort),
      .cfg_rate_sel  (cfg_rate_sel),
      .cfg_pretrig   (cfg_pretrig),
      .cfg_trig_mask (cfg_trig_mask),
      .cfg_trig_val  (cfg_trig_val),
      .din           (din),
      .sample_en     (sample_en),
      .rate_sel      (rate_sel),
      .wr_en         (wr_en),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .busy          (busy),
      .done          (done),
      .trig_addr     (trig_addr),
      .start_addr    (start_addr)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: samples are numbered from the accepted arm; sample i
   // lands at i mod DEPTH, and the capture ends DEPTH-1-pretrig samples
   // after the first matching sample whose index is at least pretrig.
   bit             m_active, m_done, m_found;
   int             m_idx, m_pre, m_trig_idx, m_trig_addr, m_start_addr;
   logic [7:0]     m_mask, m_val;
   logic [2:0]     m_rate;
   bit             e_wr_en;
   int             e_wr_addr;
   logic [7:0]     e_wr_data;

   int             wr_count, last_wr_addr;
   bit             saw_wrap;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_active = 0; m_done = 0; m_found = 0;
      m_idx = 0; m_pre = 0; m_trig_idx = 0; m_trig_addr = 0; m_start_addr = 0;
      m_mask = '0; m_val = '0; m_rate = '0;
      e_wr_en = 0; e_wr_addr = 0; e_wr_data = '0;
   endtask

   task automatic model_clock();
      e_wr_en = 0;
      if (abort) begin
         m_active = 0;
         m_done   = 0;
      end else if (!m_active) begin
         if (arm) begin
            m_pre = int'(cfg_pretrig); m_mask = cfg_trig_mask; m_val = cfg_trig_val;
            m_rate = cfg_rate_sel;
            m_active = 1; m_done = 0; m_found = 0; m_idx = 0;
            m_trig_addr = 0; m_start_addr = 0;
         end
      end else if (sample_en) begin
         e_wr_en   = 1;
         e_wr_addr = m_idx % DEPTH;
         e_wr_data = din;
         if (!m_found && m_idx >= m_pre && ((din ^ m_val) & m_mask) == 8'h00) begin
            m_found      = 1;
            m_trig_idx   = m_idx;
            m_trig_addr  = m_idx % DEPTH;
            m_start_addr = (m_idx - m_pre) % DEPTH;
         end
         if (m_found && m_idx == m_trig_idx + DEPTH - 1 - m_pre) begin
            m_active = 0;
            m_done   = 1;
         end
         m_idx++;
      end
   endtask

   task automatic compare_outputs();
      check("wr_en", wr_en, e_wr_en);
      if (e_wr_en) begin
         check("wr_addr", wr_addr, e_wr_addr);
         check("wr_data", wr_data, e_wr_data);
      end
      check("busy", busy, m_active);
      check("done", done, m_done);
      check("rate_sel", rate_sel, m_rate);
      check("trig_addr", trig_addr, m_trig_addr);
      check("start_addr", start_addr, m_start_addr);
      if (wr_en) begin
         wr_count++;
         if (last_wr_addr == DEPTH - 1 && int'(wr_addr) == 0) saw_wrap = 1;
         last_wr_addr = int'(wr_addr);
      end
   endtask

   // One clock: the model consumes this cycle's inputs, outputs are checked
   // just after the edge, then one-cycle requests are dropped.
   task automatic step();
      @(posedge clk);
      model_clock();
      #1;
      compare_outputs();
      arm   = 1'b0;
      abort = 1'b0;
   endtask

   task automatic clear_stats();
      wr_count = 0; last_wr_addr = -1; saw_wrap = 0;
   endtask

   task automatic do_arm(input logic [2:0] rs, input int pre, input logic [7:0] mask,
                         input logic [7:0] val);
      cfg_rate_sel  = rs;
      cfg_pretrig   = ADDR_W'(pre);
      cfg_trig_mask = mask;
      cfg_trig_val  = val;
      arm           = 1'b1;
      step();
   endtask

   // Counting din, sample_en tied high, run until done or max_cycles.
   task automatic run_counting(input int max_cycles);
      int cnt = 0;
      sample_en = 1'b1;
      for (int c = 0; c < max_cycles && !done; c++) begin
         din = 8'(cnt);
         step();
         cnt++;
      end
   endtask

   task automatic scenario1(input string pfx);
      clear_stats();
      do_arm(3'd0, 4, 8'hFF, 8'h0A);
      run_counting(60);
      check({pfx, "_done"}, done, 1);
      check({pfx, "_busy"}, busy, 0);
      check({pfx, "_trig"}, trig_addr, 'h0A);
      check({pfx, "_start"}, start_addr, 'h06);
      check({pfx, "_last_addr"}, last_wr_addr, 5);
      check({pfx, "_writes"}, wr_count, 22);
   endtask

   initial begin
      model_reset();
      clear_stats();
      #12;
      check("reset_outputs", {rate_sel, wr_en, wr_addr, wr_data, busy, done, trig_addr,
                              start_addr}, 0);
      rst_n = 1'b1;

      // Scenario 1: pretrig 4, trigger on 0x0A with counting data.
      scenario1("s1");

      // Scenario 2: no pretrig, mask 0 triggers on first sample.
      clear_stats();
      do_arm(3'd1, 0, 8'h00, 8'h00);
      run_counting(40);
      check("s2_done", done, 1);
      check("s2_trig", trig_addr, 0);
      check("s2_start", start_addr, 0);
      check("s2_writes", wr_count, 16);

      // Scenario 3: maximum pretrig, pointer wraps, zero post samples.
      clear_stats();
      do_arm(3'd2, 15, 8'h01, 8'h01);
      sample_en = 1'b1;
      for (int c = 0; c < 60 && !done; c++) begin
         din = (c < 30) ? 8'h00 : 8'h01;
         step();
         if (done) check("s3_done_with_write", wr_en, 1);
      end
      check("s3_done", done, 1);
      check("s3_wrap", saw_wrap, 1);
      check("s3_trig", trig_addr, 14);
      check("s3_start", start_addr, 15);
      check("s3_writes", wr_count, 31);

      // Scenario 4: sparse sample_en, rate_sel programmed.
      clear_stats();
      sample_en = 1'b0;
      do_arm(3'd5, 2, 8'hFF, 8'h03);
      check("s4_rate", rate_sel, 5);
      begin
         int cnt = 0;
         for (int c = 0; c < 200 && !done; c++) begin
            sample_en = (c % 3 == 2);
            din = 8'(cnt);
            step();
            if (sample_en) cnt++;
         end
      end
      check("s4_done", done, 1);
      check("s4_writes", wr_count, 17);

      // Scenario 5: ignored arm while busy, abort with sample_en, arm+abort.
      do_arm(3'd3, 4, 8'hFF, 8'h0A);
      sample_en = 1'b1;
      for (int c = 0; c < 14; c++) begin
         din = 8'(c);
         step();
      end
      cfg_rate_sel = 3'd7; cfg_pretrig = '0; arm = 1'b1;
      din = 8'd14;
      step();
      check("s5_arm_ignored", rate_sel, 3);
      check("s5_still_busy", busy, 1);
      abort = 1'b1;
      din = 8'd15;
      step();
      check("s5_abort_nowrite", wr_en, 0);
      check("s5_abort_busy", busy, 0);
      check("s5_abort_done", done, 0);
      check("s5_abort_rate", rate_sel, 3);
      arm = 1'b1; abort = 1'b1;
      step();
      check("s5_arm_abort_idle", busy, 0);
      step();
      check("s5_idle_nowrite", wr_en, 0);

      // Scenario 6: asynchronous reset mid-POST, then a clean capture.
      do_arm(3'd4, 4, 8'hFF, 8'h0A);
      sample_en = 1'b1;
      for (int c = 0; c < 14; c++) begin
         din = 8'(c);
         step();
      end
      #2 rst_n = 1'b0;
      #1;
      check("s6_async_reset", {rate_sel, wr_en, wr_addr, wr_data, busy, done, trig_addr,
                               start_addr}, 0);
      model_reset();
      #13 rst_n = 1'b1;
      scenario1("s6");

      // Random traffic against the model.
      for (int c = 0; c < 4000; c++) begin
         sample_en = ($urandom_range(0, 2) != 0);
         din       = 8'($urandom);
         abort     = ($urandom_range(0, 149) == 0);
         if ($urandom_range(0, 19) == 0) begin
            arm           = 1'b1;
            cfg_rate_sel  = 3'($urandom);
            cfg_pretrig   = ADDR_W'($urandom);
            cfg_trig_mask = 8'($urandom & $urandom & $urandom);
            cfg_trig_val  = 8'($urandom);
         end
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
